// File: rtl/au_pkt_pkg.sv
// ---------------------------------------------------------------------------
// au_pkt_pkg
// Shared types and helpers for the audio packetizer.
//   state_t           : packetizer FSM states
//   DROP_CNT_W        : width of the saturating drop counter
//   SEQ_BYTES         : bytes of sequence number at the start of the payload
//   PAYLOAD_OFS       : offset of frame data relative to the payload start
//   bytes_per_sample  : bytes occupied by one sample of a given width
//   pkt_bytes         : payload bytes of one complete packet
// Build option: AU_PKT_SEQ_NUM_EN adds a 16-bit little-endian sequence
// number in payload bytes 0..1 and the SEQ state.
// ---------------------------------------------------------------------------
package au_pkt_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
`ifdef AU_PKT_SEQ_NUM_EN
      ST_SEQ   = 2'd1,
`endif
      ST_WRITE = 2'd2,
      ST_CHECK = 2'd3
   } state_t;

   localparam int DROP_CNT_W = 8;

`ifdef AU_PKT_SEQ_NUM_EN
   localparam int SEQ_BYTES = 2;
`else
   localparam int SEQ_BYTES = 0;
`endif

   localparam int PAYLOAD_OFS = SEQ_BYTES;

   function automatic int bytes_per_sample(input int sample_w);
      return (sample_w + 7) / 8;
   endfunction

   function automatic int pkt_bytes(input int nchan, input int sample_w, input int frames);
      return SEQ_BYTES + frames * nchan * bytes_per_sample(sample_w);
   endfunction

endpackage

// File: rtl/au_pkt_serializer.sv
// ---------------------------------------------------------------------------
// au_pkt_serializer
// Captures one frame of NCHAN signed samples, sign-extends each to whole
// bytes and presents it one byte per step, channel 0 first, little-endian.
//   clk, rst_n : clock, asynchronous active-low reset
//   cap        : capture din into the shift register
//   next       : present the next byte on data (with cap: present byte 0)
//   din        : flattened samples, channel 0 in the LSBs
//   data       : currently presented byte (registered)
//   done       : data holds the last byte of the frame
// ---------------------------------------------------------------------------
module au_pkt_serializer
   import au_pkt_pkg::*;
#(
   parameter int NCHAN    = 2,
   parameter int SAMPLE_W = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cap,
   input  logic                      next,
   input  logic [NCHAN*SAMPLE_W-1:0] din,
   output logic [7:0]                data,
   output logic                      done
);

   localparam int B      = bytes_per_sample(SAMPLE_W);
   localparam int NBYTES = NCHAN * B;
   localparam int WORD_W = 8 * NBYTES;
   localparam int CNT_W  = $clog2(NBYTES + 1);

   logic [WORD_W-1:0] ext_word;
   logic [WORD_W-1:0] sreg;
   logic [CNT_W-1:0]  rem;

   // NOTE: every variable assigned in always_comb gets a default first, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      ext_word = '0;
      for (int ch = 0; ch < NCHAN; ch++) begin
         ext_word[ch*8*B +: 8*B] = (8*B)'($signed(din[ch*SAMPLE_W +: SAMPLE_W]));
      end
   end

   // NOTE: pure datapath storage is left without reset; it is always loaded
   // by cap before anything reads it, and rem=0 marks it as empty.
   always_ff @(posedge clk) begin
      if (cap && next) begin
         sreg <= ext_word >> 8;
      end else if (cap) begin
         sreg <= ext_word;
      end else if (next) begin
         sreg <= sreg >> 8;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data <= '0;
         rem  <= '0;
      end else if (cap && next) begin
         data <= ext_word[7:0];
         rem  <= CNT_W'(NBYTES - 1);
      end else if (cap) begin
         rem  <= CNT_W'(NBYTES);
      end else if (next) begin
         data <= sreg[7:0];
         rem  <= rem - CNT_W'(1);
      end
   end

   assign done = (rem == '0);

endmodule

// File: rtl/au_packetizer.sv
// ---------------------------------------------------------------------------
// au_packetizer
// Captures NCHAN PCM samples per strobe and writes them byte-wise into a
// ping-pong packet BRAM. A full bank is handed to the Ethernet transmitter
// while capture continues into the other bank; if the transmitter is busy
// the packet is dropped and the bank is refilled.
//   clk, rst_n : clock, asynchronous active-low reset
//   pcm_stb    : one-cycle frame strobe
//   pcm_data   : flattened signed samples, channel 0 in the LSBs
//   eth_busy   : transmitter busy, sampled when a packet completes
//   wr_en      : BRAM write enable
//   wr_addr    : BRAM byte address, MSB selects the bank
//   wr_data    : BRAM write data
//   eth_start  : one-cycle send request
//   eth_bank   : bank to send, valid with eth_start
//   drop_cnt   : saturating count of dropped packets
//   miss       : sticky, a strobe arrived while a frame was in progress
// Build option: AU_PKT_SEQ_NUM_EN prefixes each packet payload with a
// 16-bit little-endian sequence number.
// ---------------------------------------------------------------------------
module au_packetizer
   import au_pkt_pkg::*;
#(
   parameter int NCHAN          = 2,
   parameter int SAMPLE_W       = 16,
   parameter int FRAMES_PER_PKT = 32,
   parameter int HDR_LEN        = 14,
   parameter int ADDR_W         = 11
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      pcm_stb,
   input  logic [NCHAN*SAMPLE_W-1:0] pcm_data,
   input  logic                      eth_busy,
   output logic                      wr_en,
   output logic [ADDR_W-1:0]         wr_addr,
   output logic [7:0]                wr_data,
   output logic                      eth_start,
   output logic                      eth_bank,
   output logic [DROP_CNT_W-1:0]     drop_cnt,
   output logic                      miss
);

   localparam int PKT_BYTES  = pkt_bytes(NCHAN, SAMPLE_W, FRAMES_PER_PKT);
   localparam int BANK_BYTES = 2 ** (ADDR_W - 1);
   localparam int OFS_W      = ADDR_W - 1;
   localparam int FC_W       = $clog2(FRAMES_PER_PKT + 1);

   if (NCHAN < 1 || NCHAN > 16 || SAMPLE_W < 1 || SAMPLE_W > 24 ||
       FRAMES_PER_PKT < 1 || HDR_LEN + PKT_BYTES > BANK_BYTES) begin : g_bad_params
      $error("au_packetizer: parameters out of range or packet does not fit a bank");
   end

   state_t           state;
   logic             bank;
   logic [OFS_W-1:0] ofs;        // payload-relative offset of the next write
   logic [FC_W-1:0]  frame_cnt;
   logic             start_frame;
   logic             pkt_done;
   logic             ser_next;
   logic             ser_last;
   logic [7:0]       ser_data;
   logic [OFS_W-1:0] next_ofs_addr;

   assign start_frame   = (state == ST_IDLE) && pcm_stb;
   assign pkt_done      = (frame_cnt == FC_W'(FRAMES_PER_PKT - 1));
   assign next_ofs_addr = OFS_W'(HDR_LEN) + ofs;

`ifdef AU_PKT_SEQ_NUM_EN
   logic [15:0] seq;
   logic        seq_hi;
   logic        sel_seq;
   logic [7:0]  seq_data;
   logic        seq_first;

   assign seq_first = (frame_cnt == '0);
   // The serializer presents byte 0 when the last sequence byte retires.
   assign ser_next  = (start_frame && !seq_first) ||
                      ((state == ST_SEQ) && seq_hi) ||
                      ((state == ST_WRITE) && !ser_last);
   assign wr_data   = sel_seq ? seq_data : ser_data;
`else
   assign ser_next  = start_frame || ((state == ST_WRITE) && !ser_last);
   assign wr_data   = ser_data;
`endif

   au_pkt_serializer #(
      .NCHAN    (NCHAN),
      .SAMPLE_W (SAMPLE_W)
   ) u_ser (
      .clk   (clk),
      .rst_n (rst_n),
      .cap   (start_frame),
      .next  (ser_next),
      .din   (pcm_data),
      .data  (ser_data),
      .done  (ser_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         bank      <= 1'b0;
         ofs       <= '0;
         frame_cnt <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         eth_start <= 1'b0;
         eth_bank  <= 1'b0;
         drop_cnt  <= '0;
         miss      <= 1'b0;
`ifdef AU_PKT_SEQ_NUM_EN
         seq       <= '0;
         seq_hi    <= 1'b0;
         sel_seq   <= 1'b0;
         seq_data  <= '0;
`endif
      end else begin
         eth_start <= 1'b0;
         if (pcm_stb && (state != ST_IDLE)) begin
            miss <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (pcm_stb) begin
                  wr_en   <= 1'b1;
                  wr_addr <= {bank, next_ofs_addr};
                  ofs     <= ofs + OFS_W'(1);
`ifdef AU_PKT_SEQ_NUM_EN
                  if (seq_first) begin
                     state    <= ST_SEQ;
                     sel_seq  <= 1'b1;
                     seq_hi   <= 1'b0;
                     seq_data <= seq[7:0];
                  end else begin
                     state <= ST_WRITE;
                  end
`else
                  state <= ST_WRITE;
`endif
               end
            end

`ifdef AU_PKT_SEQ_NUM_EN
            ST_SEQ: begin
               wr_addr <= {bank, next_ofs_addr};
               ofs     <= ofs + OFS_W'(1);
               if (!seq_hi) begin
                  seq_hi   <= 1'b1;
                  seq_data <= seq[15:8];
               end else begin
                  sel_seq <= 1'b0;
                  state   <= ST_WRITE;
               end
            end
`endif

            ST_WRITE: begin
               if (ser_last) begin
                  wr_en <= 1'b0;
                  state <= ST_CHECK;
               end else begin
                  wr_addr <= {bank, next_ofs_addr};
                  ofs     <= ofs + OFS_W'(1);
               end
            end

            ST_CHECK: begin
               state <= ST_IDLE;
               if (pkt_done) begin
                  frame_cnt <= '0;
                  ofs       <= '0;
                  if (!eth_busy) begin
                     eth_start <= 1'b1;
                     eth_bank  <= bank;
                     bank      <= ~bank;
`ifdef AU_PKT_SEQ_NUM_EN
                     seq       <= seq + 16'd1;
`endif
                  end else if (drop_cnt != '1) begin
                     drop_cnt <= drop_cnt + DROP_CNT_W'(1);
                  end
               end else begin
                  frame_cnt <= frame_cnt + FC_W'(1);
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_au_packetizer.sv
// ---------------------------------------------------------------------------
// tb_au_packetizer
// Bench for au_packetizer. The main instance uses default parameters and is
// checked against a scoreboard of expected BRAM writes and send requests.
// Two small instances cover 24-bit and 12-bit sample sign extension and
// drop counter saturation. Honours AU_PKT_SEQ_NUM_EN when defined.
// ---------------------------------------------------------------------------
module tb_au_packetizer;

`ifdef AU_PKT_SEQ_NUM_EN
   localparam int SEQ_B = 2;
`else
   localparam int SEQ_B = 0;
`endif
   localparam int FPP = 32;
   localparam int HDR = 14;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // main instance
   logic        pcm_stb = 1'b0;
   logic [31:0] pcm_data = '0;
   logic        eth_busy = 1'b0;
   logic        wr_en;
   logic [10:0] wr_addr;
   logic [7:0]  wr_data;
   logic        eth_start;
   logic        eth_bank;
   logic [7:0]  drop_cnt;
   logic        miss;

   au_packetizer dut (
      .clk(clk), .rst_n(rst_n), .pcm_stb(pcm_stb), .pcm_data(pcm_data),
      .eth_busy(eth_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .eth_start(eth_start), .eth_bank(eth_bank), .drop_cnt(drop_cnt), .miss(miss)
   );

   // 24-bit, 1 channel, 1 frame per packet
   logic        stb_w = 1'b0;
   logic [23:0] data_w = '0;
   logic        busy_w = 1'b0;
   logic        wr_en_w, eth_start_w, eth_bank_w, miss_w;
   logic [10:0] wr_addr_w;
   logic [7:0]  wr_data_w, drop_w;

   au_packetizer #(.NCHAN(1), .SAMPLE_W(24), .FRAMES_PER_PKT(1)) dut_w (
      .clk(clk), .rst_n(rst_n), .pcm_stb(stb_w), .pcm_data(data_w),
      .eth_busy(busy_w), .wr_en(wr_en_w), .wr_addr(wr_addr_w), .wr_data(wr_data_w),
      .eth_start(eth_start_w), .eth_bank(eth_bank_w), .drop_cnt(drop_w), .miss(miss_w)
   );

   // 12-bit, 1 channel, 4 frames per packet
   logic        stb_n = 1'b0;
   logic [11:0] data_n = '0;
   logic        busy_n = 1'b0;
   logic        wr_en_n, eth_start_n, eth_bank_n, miss_n;
   logic [10:0] wr_addr_n;
   logic [7:0]  wr_data_n, drop_n;

   au_packetizer #(.NCHAN(1), .SAMPLE_W(12), .FRAMES_PER_PKT(4)) dut_n (
      .clk(clk), .rst_n(rst_n), .pcm_stb(stb_n), .pcm_data(data_n),
      .eth_busy(busy_n), .wr_en(wr_en_n), .wr_addr(wr_addr_n), .wr_data(wr_data_n),
      .eth_start(eth_start_n), .eth_bank(eth_bank_n), .drop_cnt(drop_n), .miss(miss_n)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // scoreboard and reference model for the main instance
   logic [18:0] exp_wr[$];     // {addr, data}
   logic        exp_eth[$];
   logic [7:0]  mem [0:2047];
   int          n_eth = 0;
   logic        m_bank = 1'b0;
   int          m_ofs = 0;
   int          m_frame = 0;
   logic [15:0] m_seq = '0;

   logic [18:0] log_w[$];
   logic [18:0] log_n[$];
   int          n_eth_w = 0;
   int          n_eth_n = 0;
   logic        bank_seen_w = 1'b1;

   always @(negedge clk) begin
      if (rst_n) begin
         if (wr_en) begin
            mem[wr_addr] = wr_data;
            if (exp_wr.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL spurious_wr: write addr 0x%0h data 0x%0h, expected no write", wr_addr, wr_data);
            end else begin
               logic [18:0] e;
               e = exp_wr.pop_front();
               check("wr_addr", 32'(wr_addr), 32'(e[18:8]));
               check("wr_data", 32'(wr_data), 32'(e[7:0]));
            end
         end
         if (eth_start) begin
            n_eth++;
            if (exp_eth.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL spurious_eth_start: bank %0d, expected no send", eth_bank);
            end else begin
               logic b;
               b = exp_eth.pop_front();
               check("eth_bank", 32'(eth_bank), 32'(b));
            end
         end
         if (wr_en_w) log_w.push_back({wr_addr_w, wr_data_w});
         if (wr_en_n) log_n.push_back({wr_addr_n, wr_data_n});
         if (eth_start_w) begin
            n_eth_w++;
            bank_seen_w = eth_bank_w;
         end
         if (eth_start_n) n_eth_n++;
      end
   end

   task automatic push_wr(input logic [7:0] d);
      exp_wr.push_back({m_bank, 10'(HDR + m_ofs), d});
      m_ofs++;
   endtask

   // Drive one strobe (one sampled edge), queue the expected writes and
   // advance the model as if the frame completes.
   task automatic strobe(input logic [15:0] s0, input logic [15:0] s1, input logic busy);
      @(negedge clk);
      pcm_data = {s1, s0};
      pcm_stb  = 1'b1;
      eth_busy = busy;
`ifdef AU_PKT_SEQ_NUM_EN
      if (m_frame == 0) begin
         push_wr(m_seq[7:0]);
         push_wr(m_seq[15:8]);
      end
`endif
      push_wr(s0[7:0]);
      push_wr(s0[15:8]);
      push_wr(s1[7:0]);
      push_wr(s1[15:8]);
      if (m_frame == FPP - 1) begin
         if (!busy) begin
            exp_eth.push_back(m_bank);
            m_bank = ~m_bank;
            m_seq++;
         end
         m_frame = 0;
         m_ofs   = 0;
      end else begin
         m_frame++;
      end
      @(negedge clk);
      pcm_stb = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] s0, input logic [15:0] s1, input logic busy);
      strobe(s0, s1, busy);
      repeat (10) @(negedge clk);
   endtask

   task automatic pulse_w(input logic [23:0] d);
      @(negedge clk);
      data_w = d;
      stb_w  = 1'b1;
      @(negedge clk);
      stb_w = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic pulse_n(input logic [11:0] d);
      @(negedge clk);
      data_n = d;
      stb_n  = 1'b1;
      @(negedge clk);
      stb_n = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   typedef struct {
      logic [15:0] s0;
      logic [15:0] s1;
      logic        busy;
      int          reps;
      logic        inc;
   } vec_t;

   vec_t        vecs[4];
   logic [7:0]  pat[4];

   initial begin
      // bank 0 packet, bank 1 filled to its last frame, last frame finds the
      // transmitter busy, then the refilled bank 1 starts again at offset 14
      vecs[0] = '{16'h1234, 16'hABCD, 1'b0, 32, 1'b0};
      vecs[1] = '{16'h0100, 16'h8000, 1'b0, 31, 1'b1};
      vecs[2] = '{16'h7FFF, 16'hFFFF, 1'b1, 1,  1'b0};
      vecs[3] = '{16'h5555, 16'hAAAA, 1'b0, 1,  1'b0};
      pat[0] = 8'h34; pat[1] = 8'h12; pat[2] = 8'hCD; pat[3] = 8'hAB;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_wr_en",     32'(wr_en),     32'd0);
      check("rst_eth_start", 32'(eth_start), 32'd0);
      check("rst_drop_cnt",  32'(drop_cnt),  32'd0);
      check("rst_miss",      32'(miss),      32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // table-driven frames
      for (int i = 0; i < 4; i++) begin
         for (int r = 0; r < vecs[i].reps; r++) begin
            send_frame(vecs[i].s0 + (vecs[i].inc ? 16'(r) : 16'd0),
                       vecs[i].s1 + (vecs[i].inc ? 16'(r) : 16'd0), vecs[i].busy);
         end
      end

      for (int k = 0; k < 128; k++) begin
         check("bank0_pattern", 32'(mem[HDR + SEQ_B + k]), 32'(pat[k % 4]));
      end
      check("eth_start_count", 32'(n_eth), 32'd1);
      check("drop_cnt_busy",   32'(drop_cnt), 32'd1);
      check("bank1_refill",    32'(mem[1024 + HDR + SEQ_B]), 32'h55);
      check("bank1_frame1",    32'(mem[1024 + HDR + SEQ_B + 4]), 32'h01);
      check("miss_clear",      32'(miss), 32'd0);

      // second strobe two cycles after the first is ignored and flagged
      strobe(16'h0D0C, 16'h0F0E, 1'b0);
      @(negedge clk);
      pcm_data = 32'hDEADBEEF;
      pcm_stb  = 1'b1;
      @(negedge clk);
      pcm_stb = 1'b0;
      repeat (10) @(negedge clk);
      check("miss_set", 32'(miss), 32'd1);
      send_frame(16'h2211, 16'h4433, 1'b0);
      check("miss_sticky", 32'(miss), 32'd1);
      check("wr_queue_after_miss", 32'(exp_wr.size()), 32'd0);

      // 24-bit sign extension
      pulse_w(24'hFFFFFE);
      check("w_nbytes", 32'(log_w.size()), 32'd3);
      if (log_w.size() == 3) begin
         check("w_byte0", 32'(log_w[0]), 32'({11'd14, 8'hFE}));
         check("w_byte1", 32'(log_w[1]), 32'({11'd15, 8'hFF}));
         check("w_byte2", 32'(log_w[2]), 32'({11'd16, 8'hFF}));
      end
      check("w_eth_start", 32'(n_eth_w), 32'd1);
      check("w_eth_bank",  32'(bank_seen_w), 32'd0);

      // drop counter saturation
      busy_w = 1'b1;
      for (int k = 0; k < 254; k++) pulse_w(24'(k));
      check("w_drop_254", 32'(drop_w), 32'd254);
      for (int k = 0; k < 46; k++) pulse_w(24'(k));
      check("w_drop_sat", 32'(drop_w), 32'd255);
      check("w_eth_after_drops", 32'(n_eth_w), 32'd1);
      check("w_miss", 32'(miss_w), 32'd0);

      // 12-bit sign extension
      pulse_n(12'h800);
      pulse_n(12'h7FF);
      check("n_nbytes", 32'(log_n.size()), 32'd4);
      if (log_n.size() == 4) begin
         check("n_byte0", 32'(log_n[0]), 32'({11'd14, 8'h00}));
         check("n_byte1", 32'(log_n[1]), 32'({11'd15, 8'hF8}));
         check("n_byte2", 32'(log_n[2]), 32'({11'd16, 8'hFF}));
         check("n_byte3", 32'(log_n[3]), 32'({11'd17, 8'h07}));
      end
      check("n_no_eth", 32'(n_eth_n), 32'd0);

      // reset in the middle of a frame
      strobe(16'h1111, 16'h2222, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      exp_wr.delete();
      exp_eth.delete();
      m_bank = 1'b0; m_ofs = 0; m_frame = 0; m_seq = '0;
      #1;
      check("midrst_wr_en",     32'(wr_en),     32'd0);
      check("midrst_wr_addr",   32'(wr_addr),   32'd0);
      check("midrst_wr_data",   32'(wr_data),   32'd0);
      check("midrst_eth_start", 32'(eth_start), 32'd0);
      check("midrst_eth_bank",  32'(eth_bank),  32'd0);
      check("midrst_drop_cnt",  32'(drop_cnt),  32'd0);
      check("midrst_miss",      32'(miss),      32'd0);
      check("midrst_w_drop",    32'(drop_w),    32'd0);
      check("midrst_w_bank",    32'(eth_bank_w | eth_bank_n), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_frame(16'h3333, 16'h4444, 1'b0);
      check("post_rst_byte0", 32'(mem[HDR + SEQ_B]), 32'h33);

      repeat (5) @(negedge clk);
      check("wr_queue_drained",  32'(exp_wr.size()),  32'd0);
      check("eth_queue_drained", 32'(exp_eth.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
